combat_arbiter: RTL

Per-frame hit resolution controller that sits downstream of the hit calculation pipeline. Once per game frame it waits for the pipeline to settle, samples both players' connect flags, and arbitrates the outcome: single hit, clash, or ignored. It then applies damage, hitstun and per-attack single-hit locking, and detects knockout to end the round. Its health, stun and round outputs feed the player state machines and the HUD renderer.

---
 rtl/combat_arbiter_if.sv | 33 +++
 rtl/combat_arbiter.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/combat_arbiter_if.sv
// rtl/combat_arbiter_if.sv - frame, player and result signals between game logic and combat_arbiter
interface combat_arbiter_if #(
    parameter int STATE_DEPTH  = 3,
    parameter int HEALTH_DEPTH = 4
);
    logic                    i_frame_tick;
    logic                    i_new_round;
    logic [STATE_DEPTH-1:0]  i_p1_state;
    logic [STATE_DEPTH-1:0]  i_p2_state;
    logic                    i_p1_connects;
    logic                    i_p2_connects;
    logic [HEALTH_DEPTH-1:0] o_p1_health;
    logic [HEALTH_DEPTH-1:0] o_p2_health;
    logic                    o_p1_hit;
    logic                    o_p2_hit;
    logic                    o_clash;
    logic                    o_p1_stunned;
    logic                    o_p2_stunned;
    logic                    o_round_over;
    logic [1:0]              o_winner;

    modport master (
        output i_frame_tick, i_new_round, i_p1_state, i_p2_state, i_p1_connects, i_p2_connects,
        input  o_p1_health, o_p2_health, o_p1_hit, o_p2_hit, o_clash,
               o_p1_stunned, o_p2_stunned, o_round_over, o_winner
    );

    modport slave (
        input  i_frame_tick, i_new_round, i_p1_state, i_p2_state, i_p1_connects, i_p2_connects,
        output o_p1_health, o_p2_health, o_p1_hit, o_p2_hit, o_clash,
               o_p1_stunned, o_p2_stunned, o_round_over, o_winner
    );
endinterface

// File: rtl/combat_arbiter.sv
// rtl/combat_arbiter.sv - per-frame hit arbitration: clash/hit/ignore, damage, hitstun, KO
module combat_arbiter #(
    parameter int                     STATE_DEPTH    = 3,
    parameter logic [STATE_DEPTH-1:0] KICK           = 3'd3,
    parameter logic [STATE_DEPTH-1:0] GRAB           = 3'd4,
    parameter int                     HEALTH_DEPTH   = 4,
    parameter int                     HEALTH_MAX     = 10,
    parameter int                     KICK_DAMAGE    = 2,
    parameter int                     GRAB_DAMAGE    = 3,
    parameter int                     HITSTUN_FRAMES = 12,
    parameter int                     SAMPLE_DELAY   = 3
) (
    input logic             clk,
    input logic             reset,
    combat_arbiter_if.slave bus
);
    localparam logic [HEALTH_DEPTH-1:0] HMAX      = HEALTH_DEPTH'(HEALTH_MAX);
    localparam logic [HEALTH_DEPTH-1:0] KDMG      = HEALTH_DEPTH'(KICK_DAMAGE);
    localparam logic [HEALTH_DEPTH-1:0] GDMG      = HEALTH_DEPTH'(GRAB_DAMAGE);
    localparam logic [7:0]              STUN_LOAD = 8'(HITSTUN_FRAMES);
    localparam logic [7:0]              CNT_LOAD  = 8'(SAMPLE_DELAY - 1);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESOLVE, S_KO} state_t;

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic [7:0]              r_cnt;
    logic [HEALTH_DEPTH-1:0] r_p1_health;
    logic [HEALTH_DEPTH-1:0] r_p2_health;
    logic [7:0]              r_p1_stun;
    logic [7:0]              r_p2_stun;
    logic                    r_p1_spent;
    logic                    r_p2_spent;
    logic                    r_p1_hit;
    logic                    r_p2_hit;
    logic                    r_clash;
    logic                    r_round_over;
    logic [1:0]              r_winner;

    logic                    w_resolve;
    logic                    w_running;
    logic                    w_p1_atk;
    logic                    w_p2_atk;
    logic                    w_p1_elig;
    logic                    w_p2_elig;
    logic [HEALTH_DEPTH-1:0] w_p1_dmg;
    logic [HEALTH_DEPTH-1:0] w_p2_dmg;
    logic                    w_p1_hit_now;
    logic                    w_p2_hit_now;
    logic                    w_clash_now;
    logic [HEALTH_DEPTH-1:0] w_p1_health_nxt;
    logic [HEALTH_DEPTH-1:0] w_p2_health_nxt;
    logic                    w_ko_nxt;

    function automatic logic [HEALTH_DEPTH-1:0] sat_sub(input logic [HEALTH_DEPTH-1:0] a,
                                                        input logic [HEALTH_DEPTH-1:0] b);
        return (a < b) ? '0 : a - b;
    endfunction

    assign w_p1_atk  = (bus.i_p1_state == KICK) || (bus.i_p1_state == GRAB);
    assign w_p2_atk  = (bus.i_p2_state == KICK) || (bus.i_p2_state == GRAB);
    assign w_p1_elig = bus.i_p1_connects && w_p1_atk && (r_p1_stun == 8'd0) && !r_p1_spent;
    assign w_p2_elig = bus.i_p2_connects && w_p2_atk && (r_p2_stun == 8'd0) && !r_p2_spent;
    assign w_p1_dmg  = (bus.i_p1_state == KICK) ? KDMG : GDMG;
    assign w_p2_dmg  = (bus.i_p2_state == KICK) ? KDMG : GDMG;

    // pN_hit_now means player N is the one taking the hit
    assign w_clash_now  = w_resolve && w_p1_elig && w_p2_elig;
    assign w_p2_hit_now = w_resolve && w_p1_elig && !w_p2_elig;
    assign w_p1_hit_now = w_resolve && w_p2_elig && !w_p1_elig;

    assign w_p1_health_nxt = w_p1_hit_now ? sat_sub(r_p1_health, w_p2_dmg) : r_p1_health;
    assign w_p2_health_nxt = w_p2_hit_now ? sat_sub(r_p2_health, w_p1_dmg) : r_p2_health;
    assign w_ko_nxt        = (w_p1_health_nxt == '0) || (w_p2_health_nxt == '0);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else if (bus.i_new_round) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:    if (bus.i_frame_tick) w_state_nxt = S_WAIT;
            S_WAIT:    if (r_cnt == 8'd0) w_state_nxt = S_RESOLVE;
            S_RESOLVE: w_state_nxt = w_ko_nxt ? S_KO : S_IDLE;
            S_KO:      w_state_nxt = S_KO;
            default:   w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        w_resolve = 1'b0;
        w_running = 1'b1;
        case (r_state)
            S_RESOLVE: w_resolve = 1'b1;
            S_KO:      w_running = 1'b0;
            default:   ;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt <= 8'd0;
        end else if (bus.i_new_round) begin
            r_cnt <= 8'd0;
        end else if (r_state == S_IDLE && bus.i_frame_tick) begin
            r_cnt <= CNT_LOAD;
        end else if (r_state == S_WAIT && r_cnt != 8'd0) begin
            r_cnt <= r_cnt - 8'd1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_p1_health  <= HMAX;
            r_p2_health  <= HMAX;
            r_p1_hit     <= 1'b0;
            r_p2_hit     <= 1'b0;
            r_clash      <= 1'b0;
            r_round_over <= 1'b0;
            r_winner     <= 2'b00;
        end else if (bus.i_new_round) begin
            r_p1_health  <= HMAX;
            r_p2_health  <= HMAX;
            r_p1_hit     <= 1'b0;
            r_p2_hit     <= 1'b0;
            r_clash      <= 1'b0;
            r_round_over <= 1'b0;
            r_winner     <= 2'b00;
        end else begin
            r_p1_health <= w_p1_health_nxt;
            r_p2_health <= w_p2_health_nxt;
            r_p1_hit    <= w_p1_hit_now;
            r_p2_hit    <= w_p2_hit_now;
            r_clash     <= w_clash_now;
            if (w_resolve && w_ko_nxt) begin
                r_round_over <= 1'b1;
                r_winner     <= (w_p2_health_nxt == '0) ? 2'b01 : 2'b10;
            end
        end
    end

    // A hit load in RESOLVE takes priority over a coincident tick decrement
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_p1_stun <= 8'd0;
            r_p2_stun <= 8'd0;
        end else if (bus.i_new_round) begin
            r_p1_stun <= 8'd0;
            r_p2_stun <= 8'd0;
        end else begin
            if (w_p1_hit_now) begin
                r_p1_stun <= STUN_LOAD;
            end else if (w_running && bus.i_frame_tick && r_p1_stun != 8'd0) begin
                r_p1_stun <= r_p1_stun - 8'd1;
            end
            if (w_p2_hit_now) begin
                r_p2_stun <= STUN_LOAD;
            end else if (w_running && bus.i_frame_tick && r_p2_stun != 8'd0) begin
                r_p2_stun <= r_p2_stun - 8'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_p1_spent <= 1'b0;
            r_p2_spent <= 1'b0;
        end else if (bus.i_new_round) begin
            r_p1_spent <= 1'b0;
            r_p2_spent <= 1'b0;
        end else if (w_resolve) begin
            if (w_p1_elig)     r_p1_spent <= 1'b1;
            else if (!w_p1_atk) r_p1_spent <= 1'b0;
            if (w_p2_elig)     r_p2_spent <= 1'b1;
            else if (!w_p2_atk) r_p2_spent <= 1'b0;
        end
    end

    assign bus.o_p1_health  = r_p1_health;
    assign bus.o_p2_health  = r_p2_health;
    assign bus.o_p1_hit     = r_p1_hit;
    assign bus.o_p2_hit     = r_p2_hit;
    assign bus.o_clash      = r_clash;
    assign bus.o_p1_stunned = (r_p1_stun != 8'd0);
    assign bus.o_p2_stunned = (r_p2_stun != 8'd0);
    assign bus.o_round_over = r_round_over;
    assign bus.o_winner     = r_winner;
endmodule
